// File: rtl/legv8_pkg.sv
// Shared LEGv8 control definitions: the FSM state enum, the opcode patterns, and the
// AluOp/AluSrcB encodings. The ALU control decoder imports this package too.
package legv8_pkg;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_FETCH,
    ST_DECODE,
    ST_MEM_ADDR,
    ST_MEM_RD,
    ST_MEM_WB,
    ST_MEM_WR,
    ST_R_EXEC,
    ST_R_WB,
    ST_BRANCH,
    ST_JUMP,
    ST_HALT
  } state_e;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  // CBZ is matched on opcode[10:3] and B on opcode[10:5].
  localparam logic [7:0] CBZ_PAT = 8'b10110100;
  localparam logic [5:0] B_PAT   = 6'b000101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_CBZ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [1:0] ALUSRCB_REG  = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR = 2'b01;
  localparam logic [1:0] ALUSRCB_DOFF = 2'b10;
  localparam logic [1:0] ALUSRCB_BOFF = 2'b11;

  typedef struct packed {
    logic rtype;
    logic ldur;
    logic stur;
    logic cbz;
    logic b;
    logic illegal;
  } opclass_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write;
    logic       pc_source;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg2loc;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Connects the multicycle control unit to the datapath. The master side is the
// controller; the slave side is the datapath/memory.
interface multicycle_control_if #(
  parameter int CNT_W = 32
);

  logic [10:0]      opcode;
  logic             Zero;
  logic             MemReady;
  logic [1:0]       AluOp;
  logic             AluSrcA;
  logic [1:0]       AluSrcB;
  logic             PCWrite;
  logic             PCSource;
  logic             IRWrite;
  logic             MemRead;
  logic             MemWrite;
  logic             IorD;
  logic             Reg2Loc;
  logic             RegWrite;
  logic             MemToReg;
  logic             Illegal;
  logic [CNT_W-1:0] InstrCount;

  modport master (
    input  opcode, Zero, MemReady,
    output AluOp, AluSrcA, AluSrcB, PCWrite, PCSource, IRWrite, MemRead, MemWrite,
           IorD, Reg2Loc, RegWrite, MemToReg, Illegal, InstrCount
  );

  modport slave (
    output opcode, Zero, MemReady,
    input  AluOp, AluSrcA, AluSrcB, PCWrite, PCSource, IRWrite, MemRead, MemWrite,
           IorD, Reg2Loc, RegWrite, MemToReg, Illegal, InstrCount
  );

endinterface

// File: rtl/opcode_class.sv
// Combinational instruction classifier. Exactly one bit of the result is set for
// any opcode.
module opcode_class
  import legv8_pkg::*;
(
  input  logic [10:0] opcode,
  output opclass_t    cls
);

  always_comb begin
    cls         = '0;
    cls.rtype   = opcode inside {OP_ADD, OP_SUB, OP_AND, OP_ORR};
    cls.ldur    = (opcode == OP_LDUR);
    cls.stur    = (opcode == OP_STUR);
    cls.cbz     = (opcode[10:3] == CBZ_PAT);
    cls.b       = (opcode[10:5] == B_PAT);
    cls.illegal = !(cls.rtype || cls.ldur || cls.stur || cls.cbz || cls.b);
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle LEGv8 datapath. It steps each instruction
// through fetch, decode, execute, memory and write-back, and counts retired instructions.
module multicycle_control
  import legv8_pkg::*;
#(
  parameter int ADDR_INC = 4,
  parameter int CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  // The datapath's PC-increment constant (AluSrcB=01) is fixed at 4.
  if (ADDR_INC != 4) begin : g_addr_inc_check
    $error("multicycle_control: ADDR_INC must match the datapath constant 4");
  end

  state_e           state_q;
  state_e           state_d;
  opclass_t         cls;
  ctrl_t            ctrl;
  logic             illegal_q;
  logic [CNT_W-1:0] count_q;
  logic             retire;

  opcode_class u_opcode_class (
    .opcode (bus.opcode),
    .cls    (cls)
  );

  assign retire = (state_q inside {ST_R_WB, ST_MEM_WB, ST_BRANCH, ST_JUMP}) ||
                  (state_q == ST_MEM_WR && bus.MemReady);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples values from before the clock edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_INIT;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == ST_HALT) illegal_q <= 1'b1;
      if (retire)             count_q   <= count_q + CNT_W'(1);
    end
  end

  always_comb begin
    // NOTE: the default assignment before the case ensures every path assigns
    // state_d, so no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      ST_INIT:   state_d = ST_FETCH;
      ST_FETCH:  if (bus.MemReady) state_d = ST_DECODE;
      ST_DECODE: begin
        if (cls.illegal)               state_d = ST_HALT;
        else if (cls.rtype)            state_d = ST_R_EXEC;
        else if (cls.ldur || cls.stur) state_d = ST_MEM_ADDR;
        else if (cls.cbz)              state_d = ST_BRANCH;
        else                           state_d = ST_JUMP;
      end
      ST_MEM_ADDR: state_d = cls.stur ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD:   if (bus.MemReady) state_d = ST_MEM_WB;
      ST_MEM_WR:   if (bus.MemReady) state_d = ST_FETCH;
      ST_R_EXEC:   state_d = ST_R_WB;
      ST_MEM_WB, ST_R_WB, ST_BRANCH, ST_JUMP: state_d = ST_FETCH;
      ST_HALT:     state_d = ST_HALT;
      default:     state_d = ST_INIT;
    endcase
  end

  // All outputs are Moore decodes of the state, except the MemReady-qualified
  // FETCH writes and the Zero-qualified branch PCWrite.
  always_comb begin
    ctrl = '0;
    unique case (state_q)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = ALUSRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_write  = bus.MemReady;
        ctrl.ir_write  = bus.MemReady;
      end
      ST_DECODE: begin
        ctrl.alu_src_b = ALUSRCB_BOFF;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.reg2loc   = cls.stur || cls.cbz;
      end
      ST_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_REG;
        ctrl.alu_op    = ALUOP_RTYPE;
      end
      ST_R_WB: ctrl.reg_write = 1'b1;
      ST_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_DOFF;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.reg2loc   = cls.stur;
      end
      ST_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        ctrl.reg2loc   = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_REG;
        ctrl.alu_op    = ALUOP_CBZ;
        ctrl.reg2loc   = 1'b1;
        ctrl.pc_source = 1'b1;
        ctrl.pc_write  = bus.Zero;
      end
      ST_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  assign bus.AluOp      = ctrl.alu_op;
  assign bus.AluSrcA    = ctrl.alu_src_a;
  assign bus.AluSrcB    = ctrl.alu_src_b;
  assign bus.PCWrite    = ctrl.pc_write;
  assign bus.PCSource   = ctrl.pc_source;
  assign bus.IRWrite    = ctrl.ir_write;
  assign bus.MemRead    = ctrl.mem_read;
  assign bus.MemWrite   = ctrl.mem_write;
  assign bus.IorD       = ctrl.iord;
  assign bus.Reg2Loc    = ctrl.reg2loc;
  assign bus.RegWrite   = ctrl.reg_write;
  assign bus.MemToReg   = ctrl.mem_to_reg;
  assign bus.Illegal    = illegal_q;
  assign bus.InstrCount = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the stimulus queues the expected control
// word and count for each cycle, and a negedge monitor compares them.
module tb_multicycle_control;

  localparam int CNT_W = 4;
  localparam int K_R = 0, K_LD = 1, K_ST = 2, K_CBZ = 3, K_B = 4, K_ILL = 5;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       src_a;
    logic [1:0] src_b;
    logic       pc_write;
    logic       pc_source;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg2loc;
    logic       reg_write;
    logic       mem_to_reg;
    logic       illegal;
  } word_t;

  typedef struct {
    string            name;
    word_t            w;
    logic [CNT_W-1:0] cnt;
  } rec_t;

  logic clk = 1'b0;
  logic reset;
  rec_t sb[$];
  rec_t mon_e;
  word_t mon_w;
  logic [CNT_W-1:0] exp_cnt;
  int n_cmp = 0;
  int n_bad = 0;
  logic [10:0] r_ops [4] = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};

  multicycle_control_if #(.CNT_W(CNT_W)) bus ();

  multicycle_control #(.ADDR_INC(4), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Expected outputs of each step of an instruction, read directly from the control table.
  function automatic word_t expect_of(input string ph, input bit arg);
    word_t w = '0;
    case (ph)
      "fetch":    begin w.mem_read = 1; w.src_b = 2'b01; w.pc_write = arg; w.ir_write = arg; end
      "decode":   begin w.src_b = 2'b11; w.reg2loc = arg; end
      "r_exec":   begin w.src_a = 1; w.alu_op = 2'b10; end
      "r_wb":     w.reg_write = 1;
      "mem_addr": begin w.src_a = 1; w.src_b = 2'b10; w.reg2loc = arg; end
      "mem_rd":   begin w.mem_read = 1; w.iord = 1; end
      "mem_wb":   begin w.reg_write = 1; w.mem_to_reg = 1; end
      "mem_wr":   begin w.mem_write = 1; w.iord = 1; w.reg2loc = 1; end
      "branch":   begin w.src_a = 1; w.alu_op = 2'b01; w.reg2loc = 1; w.pc_source = 1; w.pc_write = arg; end
      "jump":     begin w.pc_write = 1; w.pc_source = 1; end
      "halt":     w.illegal = 1;
      default:    w = '0;
    endcase
    return w;
  endfunction

  function automatic bit is_legal(input logic [10:0] op);
    return (op inside {11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000,
                       11'b11111000010, 11'b11111000000}) ||
           (op[10:3] == 8'b10110100) || (op[10:5] == 6'b000101);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, queue what the DUT must show this cycle, advance.
  task automatic step(input string ph, input bit arg, input logic [10:0] op, input logic z,
                      input logic rdy, input bit retire, input bit rst);
    reset        = rst;
    bus.opcode   = op;
    bus.Zero     = z;
    bus.MemReady = rdy;
    sb.push_back('{ph, expect_of(ph, arg), exp_cnt});
    @(posedge clk);
    #1;
    if (rst) exp_cnt = '0;
    else if (retire) exp_cnt = exp_cnt + 1'b1;
  endtask

  function automatic logic [10:0] rnd_op();
    return 11'($urandom);
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom);
  endfunction

  task automatic run_instr(input int kind, input logic [10:0] op, input int f_st, input int m_st,
                           input logic z, input bit abort);
    for (int i = 0; i < f_st; i++) step("fetch", 0, rnd_op(), rnd_bit(), 0, 0, 0);
    step("fetch", 1, rnd_op(), rnd_bit(), 1, 0, 0);
    step("decode", (kind == K_ST || kind == K_CBZ), op, rnd_bit(), rnd_bit(), 0, 0);
    case (kind)
      K_R: begin
        step("r_exec", 0, rnd_op(), rnd_bit(), rnd_bit(), 0, 0);
        step("r_wb", 0, rnd_op(), rnd_bit(), rnd_bit(), 1, 0);
      end
      K_LD: begin
        step("mem_addr", 0, op, rnd_bit(), rnd_bit(), 0, 0);
        for (int i = 0; i < m_st; i++) step("mem_rd", 0, rnd_op(), rnd_bit(), 0, 0, 0);
        step("mem_rd", 0, rnd_op(), rnd_bit(), 1, 0, 0);
        step("mem_wb", 0, rnd_op(), rnd_bit(), rnd_bit(), 1, 0);
      end
      K_ST: begin
        step("mem_addr", 1, op, rnd_bit(), rnd_bit(), 0, 0);
        for (int i = 0; i < m_st; i++)
          step("mem_wr", 0, rnd_op(), rnd_bit(), 0, 0, abort && (i == m_st - 1));
        if (abort) step("init", 0, rnd_op(), rnd_bit(), rnd_bit(), 0, 0);
        else       step("mem_wr", 0, rnd_op(), rnd_bit(), 1, 1, 0);
      end
      K_CBZ: step("branch", z, rnd_op(), z, rnd_bit(), 1, 0);
      K_B:   step("jump", 0, rnd_op(), rnd_bit(), rnd_bit(), 1, 0);
      default: begin
        // Halted until reset: outputs must hold for many cycles, then reset clears Illegal.
        for (int i = 0; i < 12; i++) step("halt", 0, rnd_op(), rnd_bit(), rnd_bit(), 0, i == 11);
        step("init", 0, rnd_op(), rnd_bit(), rnd_bit(), 0, 0);
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      mon_w = '{bus.AluOp, bus.AluSrcA, bus.AluSrcB, bus.PCWrite, bus.PCSource, bus.IRWrite,
                bus.MemRead, bus.MemWrite, bus.IorD, bus.Reg2Loc, bus.RegWrite, bus.MemToReg,
                bus.Illegal};
      check({mon_e.name, " ctrl"}, 32'(mon_w), 32'(mon_e.w));
      check({mon_e.name, " count"}, 32'(bus.InstrCount), 32'(mon_e.cnt));
    end
  end

  initial begin
    int k;
    logic [10:0] op;
    reset        = 1'b1;
    bus.opcode   = '0;
    bus.Zero     = 1'b0;
    bus.MemReady = 1'b0;
    exp_cnt      = '0;
    @(posedge clk);
    #1;
    step("init", 0, rnd_op(), rnd_bit(), rnd_bit(), 0, 0);

    run_instr(K_R,   11'b10001011000, 0, 0, 0, 0);
    run_instr(K_LD,  11'b11111000010, 0, 2, 0, 0);
    run_instr(K_CBZ, 11'b10110100101, 0, 0, 1, 0);
    run_instr(K_CBZ, 11'b10110100101, 0, 0, 0, 0);
    run_instr(K_B,   11'b00010100011, 1, 0, 0, 0);
    run_instr(K_ST,  11'b11111000000, 2, 1, 0, 0);
    run_instr(K_ILL, 11'b00000000000, 0, 0, 0, 0);
    run_instr(K_ST,  11'b11111000000, 0, 2, 0, 1);

    // Seventeen retires from zero pass through the 4-bit wrap.
    for (int i = 0; i < 17; i++) run_instr(K_B, {6'b000101, 5'($urandom)}, 0, 0, 0, 0);

    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 11);
      if (k <= 2)       run_instr(K_R, r_ops[$urandom_range(0, 3)], $urandom_range(0, 2), 0, 0, 0);
      else if (k <= 4)  run_instr(K_LD, 11'b11111000010, $urandom_range(0, 2), $urandom_range(0, 3), 0, 0);
      else if (k <= 6)  run_instr(K_ST, 11'b11111000000, $urandom_range(0, 2), $urandom_range(0, 3), 0, 0);
      else if (k <= 8)  run_instr(K_CBZ, {8'b10110100, 3'($urandom)}, $urandom_range(0, 2), 0, rnd_bit(), 0);
      else if (k <= 10) run_instr(K_B, {6'b000101, 5'($urandom)}, $urandom_range(0, 2), 0, 0, 0);
      else begin
        op = rnd_op();
        while (is_legal(op)) op = rnd_op();
        run_instr(K_ILL, op, $urandom_range(0, 2), 0, 0, 0);
      end
    end

    @(negedge clk);
    #1;
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
